// File: rtl/mem_multicycle_param.sv
// -----------------------------------------------------------------------------
// mem_multicycle_param
//
// Word-organised memory model with single-cycle byte-masked writes and reads
// that return after READ_LATENCY cycles. Two read engines are selectable:
//   PIPELINED=1 : a READ_LATENCY-deep {valid, data} shift pipeline, one read
//                 accepted every cycle, responses in issue order.
//   PIPELINED=0 : an IDLE/BUSY FSM with one read outstanding; ready is low
//                 while the read is in flight.
// Read data is a snapshot of the word at the accept edge.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (storage contents are kept)
//   enable     request valid
//   wr         1 = write, 0 = read (sampled with enable)
//   addr       byte address, low log2(DATA_WIDTH/8) bits ignored
//   data_in    write data
//   byte_en    per-byte write mask (ignored on reads)
//   ready      request accepted when enable & ready
//   data_out   read data, holds last returned value between pulses
//   data_valid one-cycle pulse marking data_out valid
// -----------------------------------------------------------------------------
module mem_multicycle_param #(
    parameter int    ADDR_WIDTH   = 16,
    parameter int    DATA_WIDTH   = 16,
    parameter int    READ_LATENCY = 4,
    parameter bit    PIPELINED    = 1'b1,
    parameter string INIT_FILE    = ""
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      wr,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int BYTE_OFF  = $clog2(NUM_BYTES);
    localparam int WORD_AW   = ADDR_WIDTH - BYTE_OFF;
    localparam int DEPTH     = 2 ** WORD_AW;
    localparam int CNT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [WORD_AW-1:0]    word_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  rd_accept_s;
    logic                  wr_accept_s;
    logic                  resp_fire_s;
    logic [DATA_WIDTH-1:0] resp_data_s;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_valid_r;
    logic                  unused_addr_s;

    assign word_idx_s    = addr[ADDR_WIDTH-1:BYTE_OFF];
    assign rd_word_s     = mem_r[word_idx_s];
    // Byte-offset bits only select a lane inside the word and are not decoded.
    assign unused_addr_s = ^addr[BYTE_OFF-1:0];

    // A request is only taken outside reset, even though ready reads 1 there.
    assign accept_s    = enable & ready_s & ~rst;
    assign rd_accept_s = accept_s & ~wr;
    assign wr_accept_s = accept_s & wr;

    // Byte-masked write port; bytes with a clear enable keep their value.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (byte_en[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    generate
        if (PIPELINED) begin : g_pipe
            logic [READ_LATENCY-1:0] pipe_valid_r;
            logic [DATA_WIDTH-1:0]   pipe_data_r [READ_LATENCY];

            // Read shift pipeline: stage 0 captures the snapshot at accept.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_valid_r <= '0;
                    for (int k = 0; k < READ_LATENCY; k++) begin
                        pipe_data_r[k] <= '0;
                    end
                end else begin
                    pipe_valid_r[0] <= rd_accept_s;
                    pipe_data_r[0]  <= rd_word_s;
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        pipe_valid_r[k] <= pipe_valid_r[k-1];
                        pipe_data_r[k]  <= pipe_data_r[k-1];
                    end
                end
            end

            assign ready_s     = 1'b1;
            assign resp_fire_s = pipe_valid_r[READ_LATENCY-1];
            assign resp_data_s = pipe_data_r[READ_LATENCY-1];
        end else begin : g_block
            state_t                state_r;
            state_t                state_next_s;
            logic [CNT_W-1:0]      count_r;
            logic [CNT_W-1:0]      count_next_s;
            logic [DATA_WIDTH-1:0] snap_r;

            // FSM state, latency counter and read snapshot registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_r <= IDLE;
                    count_r <= '0;
                    snap_r  <= '0;
                end else begin
                    state_r <= state_next_s;
                    count_r <= count_next_s;
                    if (rd_accept_s) begin
                        snap_r <= rd_word_s;
                    end
                end
            end

            // Next state: a read moves to BUSY; BUSY leaves as the count hits 0.
            always_comb begin
                state_next_s = state_r;
                count_next_s = count_r;
                case (state_r)
                    IDLE: begin
                        if (rd_accept_s) begin
                            state_next_s = BUSY;
                            count_next_s = CNT_W'(READ_LATENCY - 1);
                        end else begin
                            state_next_s = IDLE;
                        end
                    end
                    BUSY: begin
                        if (count_r == '0) begin
                            state_next_s = IDLE;
                        end else begin
                            count_next_s = count_r - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next_s = IDLE;
                        count_next_s = '0;
                    end
                endcase
            end

            // Outputs: the response fires on the same edge the FSM returns to IDLE.
            always_comb begin
                ready_s     = 1'b0;
                resp_fire_s = 1'b0;
                case (state_r)
                    IDLE: begin
                        ready_s     = 1'b1;
                        resp_fire_s = 1'b0;
                    end
                    BUSY: begin
                        ready_s     = 1'b0;
                        resp_fire_s = (count_r == '0);
                    end
                    default: begin
                        ready_s     = 1'b0;
                        resp_fire_s = 1'b0;
                    end
                endcase
            end

            assign resp_data_s = snap_r;
        end
    endgenerate

    // Registered response; data_out keeps its last value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= resp_fire_s;
            if (resp_fire_s) begin
                data_out_r <= resp_data_s;
            end
        end
    end

    assign ready      = ready_s;
    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;

endmodule

// File: tb/tb_mem_multicycle_param.sv
// -----------------------------------------------------------------------------
// tb_mem_multicycle_param
//
// Four configurations share one request bus, each with its own enable:
//   0: DW16, latency 4, pipelined     1: DW16, latency 3, blocking
//   2: DW32, latency 1, pipelined     3: DW16, latency 1, blocking
// A reference model (word array + pulse schedule keyed by cycle) predicts
// ready, data_valid and data_out on every cycle of the active configuration.
// -----------------------------------------------------------------------------
module tb_mem_multicycle_param;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] din;
    logic [3:0]  be;

    logic [3:0]  rdy_w;
    logic [3:0]  dv_w;
    logic [15:0] dout0, dout1, dout3;
    logic [31:0] dout2;
    logic [31:0] dout_w [4];

    assign dout_w[0] = {16'h0000, dout0};
    assign dout_w[1] = {16'h0000, dout1};
    assign dout_w[2] = dout2;
    assign dout_w[3] = {16'h0000, dout3};

    int lat   [4] = '{4, 3, 1, 1};
    int piped [4] = '{1, 0, 1, 0};
    int nb    [4] = '{2, 2, 4, 2};

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_mdl   [int];
    logic [31:0] exp_pulse [int];
    logic [31:0] last_data [4];
    int          ready_at  [4];

    mem_multicycle_param #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(4), .PIPELINED(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .wr(wr), .addr(addr), .data_in(din[15:0]),
        .byte_en(be[1:0]), .ready(rdy_w[0]), .data_out(dout0), .data_valid(dv_w[0]));
    mem_multicycle_param #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3), .PIPELINED(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .wr(wr), .addr(addr), .data_in(din[15:0]),
        .byte_en(be[1:0]), .ready(rdy_w[1]), .data_out(dout1), .data_valid(dv_w[1]));
    mem_multicycle_param #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(1), .PIPELINED(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en[2]), .wr(wr), .addr(addr), .data_in(din),
        .byte_en(be), .ready(rdy_w[2]), .data_out(dout2), .data_valid(dv_w[2]));
    mem_multicycle_param #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(1), .PIPELINED(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .enable(en[3]), .wr(wr), .addr(addr), .data_in(din[15:0]),
        .byte_en(be[1:0]), .ready(rdy_w[3]), .data_out(dout3), .data_valid(dv_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge = number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int boff(input int d);
        return (nb[d] == 4) ? 2 : 1;
    endfunction

    // One cycle on configuration d: check outputs, present a request, update model.
    task automatic cycle(input int d, input bit e, input bit w, input logic [15:0] a,
                         input logic [31:0] di, input logic [3:0] b, output bit acc);
        int          key;
        int          widx;
        bit          exp_v;
        bit          rdy_e;
        logic [31:0] word;
        key   = d * (1 << 20) + cyc;
        exp_v = exp_pulse.exists(key);
        if (exp_v) begin
            last_data[d] = exp_pulse[key];
            exp_pulse.delete(key);
        end
        rdy_e = (piped[d] != 0) || (cyc >= ready_at[d]);
        check_value($sformatf("data_valid[%0d]", d), 32'(dv_w[d]), 32'(exp_v));
        check_value($sformatf("data_out[%0d]", d), dout_w[d], last_data[d]);
        check_value($sformatf("ready[%0d]", d), 32'(rdy_w[d]), 32'(rdy_e));
        en    = 4'b0000;
        en[d] = e;
        wr    = w;
        addr  = a;
        din   = di;
        be    = b;
        acc   = e && rdy_e;
        if (acc) begin
            widx = d * (1 << 20) + int'(a >> boff(d));
            word = mem_mdl.exists(widx) ? mem_mdl[widx] : 32'h0;
            if (w) begin
                for (int i = 0; i < nb[d]; i++) begin
                    if (b[i]) word[8*i +: 8] = di[8*i +: 8];
                end
                mem_mdl[widx] = word;
            end else begin
                exp_pulse[d * (1 << 20) + cyc + 1 + lat[d]] = word;
                if (piped[d] == 0) ready_at[d] = cyc + 1 + lat[d];
            end
        end
        @(negedge clk);
        en = 4'b0000;
    endtask

    task automatic idle(input int d, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(d, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, acc);
    endtask

    // Present a request and keep it until accepted (bounded).
    task automatic hold_req(input int d, input bit w, input logic [15:0] a,
                            input logic [31:0] di, input logic [3:0] b);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(d, 1'b1, w, a, di, b, acc);
        check_value($sformatf("hold_accept[%0d]", d), 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 4'b0000;
        #1;
        for (int d = 0; d < 4; d++) begin
            check_value($sformatf("rst_valid[%0d]", d), 32'(dv_w[d]), 32'd0);
            check_value($sformatf("rst_data[%0d]", d), dout_w[d], 32'h0);
            check_value($sformatf("rst_ready[%0d]", d), 32'(rdy_w[d]), 32'd1);
            last_data[d] = 32'h0;
            ready_at[d]  = 0;
        end
        exp_pulse.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_random(input int d, input int n);
        bit          acc;
        logic [15:0] a;
        for (int i = 0; i < 16; i++)
            hold_req(d, 1'b1, 16'h0200 + 16'(i << boff(d)), $urandom, 4'hF);
        for (int i = 0; i < n; i++) begin
            a = 16'h0200 + 16'($urandom_range(0, 15) << boff(d)) + 16'($urandom_range(0, nb[d] - 1));
            cycle(d, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), acc);
        end
        idle(d, lat[d] + 2);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 4'b0000;
        wr   = 1'b0;
        addr = 16'h0;
        din  = 32'h0;
        be   = 4'h0;
        for (int d = 0; d < 4; d++) begin
            last_data[d] = 32'h0;
            ready_at[d]  = 0;
        end
        repeat (3) @(negedge clk);
        do_reset();

        // Reset with a read in flight: the pulse must never appear.
        hold_req(0, 1'b1, 16'h0040, 32'h1234, 4'h3);
        hold_req(0, 1'b0, 16'h0040, 32'h0, 4'h0);
        idle(0, 1);
        do_reset();
        idle(0, 6);
        check_value("no_late_pulse", dout_w[0], 32'h0);

        // Latency after reset.
        hold_req(0, 1'b1, 16'h0010, 32'hBEEF, 4'h3);
        hold_req(0, 1'b0, 16'h0010, 32'h0, 4'h0);
        idle(0, 5);
        check_value("beef", dout_w[0], 32'hBEEF);

        // Byte enables.
        hold_req(0, 1'b1, 16'h0020, 32'h1234, 4'h3);
        hold_req(0, 1'b1, 16'h0020, 32'hABCD, 4'h1);
        hold_req(0, 1'b0, 16'h0020, 32'h0, 4'h0);
        idle(0, 5);
        check_value("be_low", dout_w[0], 32'h12CD);
        hold_req(0, 1'b1, 16'h0020, 32'hABCD, 4'h2);
        hold_req(0, 1'b0, 16'h0021, 32'h0, 4'h0);
        idle(0, 5);
        check_value("be_high", dout_w[0], 32'hABCD);

        // Back-to-back streaming reads.
        hold_req(0, 1'b1, 16'h0000, 32'h1111, 4'h3);
        hold_req(0, 1'b1, 16'h0002, 32'h2222, 4'h3);
        hold_req(0, 1'b1, 16'h0004, 32'h3333, 4'h3);
        hold_req(0, 1'b0, 16'h0000, 32'h0, 4'h0);
        hold_req(0, 1'b0, 16'h0002, 32'h0, 4'h0);
        hold_req(0, 1'b0, 16'h0004, 32'h0, 4'h0);
        idle(0, 5);
        check_value("stream_last", dout_w[0], 32'h3333);

        // Snapshot: a write right after a read does not alter the response.
        hold_req(0, 1'b1, 16'h0030, 32'h5555, 4'h3);
        hold_req(0, 1'b0, 16'h0030, 32'h0, 4'h0);
        hold_req(0, 1'b1, 16'h0030, 32'h6666, 4'h3);
        idle(0, 5);
        check_value("snapshot_old", dout_w[0], 32'h5555);
        hold_req(0, 1'b0, 16'h0030, 32'h0, 4'h0);
        idle(0, 5);
        check_value("snapshot_new", dout_w[0], 32'h6666);
        run_random(0, 300);

        // Blocking mode: held requests wait for ready.
        hold_req(1, 1'b1, 16'h0008, 32'h0A0A, 4'h3);
        hold_req(1, 1'b1, 16'h000A, 32'h0C0C, 4'h3);
        hold_req(1, 1'b0, 16'h0008, 32'h0, 4'h0);
        hold_req(1, 1'b0, 16'h000A, 32'h0, 4'h0);
        hold_req(1, 1'b1, 16'h0008, 32'h0B0B, 4'h3);
        hold_req(1, 1'b0, 16'h0008, 32'h0, 4'h0);
        idle(1, 5);
        check_value("block_held_write", dout_w[1], 32'h0B0B);
        run_random(1, 300);

        // Wide word, latency 1, aliasing of the byte offset.
        hold_req(2, 1'b1, 16'h0104, 32'h0000_0000, 4'hF);
        hold_req(2, 1'b1, 16'h0104, 32'hDEAD_BEEF, 4'hC);
        hold_req(2, 1'b0, 16'h0104, 32'h0, 4'h0);
        idle(2, 2);
        check_value("wide_mask", dout_w[2], 32'hDEAD_0000);
        hold_req(2, 1'b1, 16'h0104, 32'h0000_00AA, 4'h1);
        hold_req(2, 1'b0, 16'h0106, 32'h0, 4'h0);
        idle(2, 2);
        check_value("wide_alias", dout_w[2], 32'hDEAD_00AA);
        run_random(2, 300);

        // Blocking mode with latency 1.
        hold_req(3, 1'b1, 16'h0050, 32'h7777, 4'h3);
        hold_req(3, 1'b0, 16'h0050, 32'h0, 4'h0);
        hold_req(3, 1'b0, 16'h0050, 32'h0, 4'h0);
        idle(3, 3);
        check_value("block_lat1", dout_w[3], 32'h7777);
        run_random(3, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
